dmem_responder: RTL

Data-memory responder serving the processor's load/store port. It accepts one request at a time over a req/gnt handshake and models a fixed access latency of LATENCY wait cycles. It performs byte-enabled writes and returns read data with a one-cycle rvalid pulse. It sits at the far end of the processor's data-address/memory-data path and replaces the ideal combinational memory in system simulation.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Load/store bus between the processor data port and the data-memory responder.
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over req/gnt, fixed LATENCY
// wait cycles, byte-enabled stores, single-cycle rvalid response.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input logic               clk,
    input logic               rst,
    dmem_responder_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;

    logic [31:0]       r_rdata;
    logic              r_err;

    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_resp_entry;
    logic              w_cur_we;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [IDX_W-1:0]  w_cur_idx;
    logic              w_cur_bad;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_commit;

    // Misaligned or beyond the storage array.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
    endfunction

    assign w_accept     = (r_state == IDLE) && bus.req;
    assign w_resp_entry = (w_next == RESP);

    // With LATENCY=0 the response is formed on the accept edge itself, before
    // the request is latched, so the response path reads the bus while in IDLE.
    assign w_cur_we   = (r_state == IDLE) ? bus.we   : r_we;
    assign w_cur_addr = (r_state == IDLE) ? bus.addr : r_addr;
    assign w_cur_idx  = w_cur_addr[IDX_W+1:2];
    assign w_cur_bad  = addr_bad(w_cur_addr);

    assign w_wr_idx = r_addr[IDX_W+1:2];
    assign w_commit = (r_state == RESP) && r_we && !addr_bad(r_addr);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.req) w_next = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 4'd1) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.gnt    = (r_state == IDLE);
        bus.busy   = (r_state != IDLE);
        bus.rvalid = (r_state == RESP);
        bus.rdata  = r_rdata;
        bus.err    = r_err;
    end

    // Wait counter: loaded on accept, counts down through WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= 4'(LATENCY);
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture the request fields on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_be    <= bus.be;
        end
    end

    // Response registers: set on RESP entry; err clears on RESP exit, rdata holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_resp_entry) begin
            r_err   <= w_cur_bad;
            r_rdata <= (w_cur_bad || w_cur_we) ? '0 : r_mem[w_cur_idx];
        end else if (r_state == RESP) begin
            r_err   <= 1'b0;
        end
    end

    // Storage: store commits on the edge leaving RESP, only enabled lanes.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_commit && r_be[i]) begin
                r_mem[w_wr_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end
endmodule
